// File: rtl/ex_pkg.sv
// ---------------------------------------------------------------------------
// ex_pkg
// Shared EX-stage definitions used by the iterative multiplier:
//   state_t       FSM states of the multiplier sequencer
//   ALUOP_RTYPE   ALUOp encoding for R-type instructions
//   FUNCT_MUL     {funct7,funct3} of RV32M MUL
//   is_mul()      decode helper: true when ID/EX holds a MUL
// ---------------------------------------------------------------------------
package ex_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [9:0] FUNCT_MUL   = 10'b0000001_000;

    function automatic logic is_mul(input logic [1:0] aluop, input logic [9:0] funct);
        return (aluop == ALUOP_RTYPE) && (funct == FUNCT_MUL);
    endfunction

endpackage

// File: rtl/ex_iter_mul_if.sv
// ---------------------------------------------------------------------------
// ex_iter_mul_if
// Bundle between the ID/EX register / hazard logic (master) and the
// iterative multiplier in EX (slave).
//   start_i     global run enable
//   ALUOp_i     ID/EX ALUOp
//   funct_i     ID/EX {funct7,funct3}
//   data1_i     rs1 value (multiplicand)
//   data2_i     rs2 value (multiplier)
//   RDaddr_i    destination register
//   RegWrite_i  ID/EX RegWrite
//   stall_o     hold PC, IF/ID, ID/EX
//   busy_o      multiplier iterating
//   done_o      one-cycle result pulse
//   result_o    low WIDTH product bits
//   RDaddr_o    rd of the finished multiply
//   RegWrite_o  RegWrite of the finished multiply, qualified by done_o
// ---------------------------------------------------------------------------
interface ex_iter_mul_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [1:0]       ALUOp_i;
    logic [9:0]       funct_i;
    logic [WIDTH-1:0] data1_i;
    logic [WIDTH-1:0] data2_i;
    logic [4:0]       RDaddr_i;
    logic             RegWrite_i;
    logic             stall_o;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;
    logic [4:0]       RDaddr_o;
    logic             RegWrite_o;

    modport master (
        output start_i, ALUOp_i, funct_i, data1_i, data2_i, RDaddr_i, RegWrite_i,
        input  stall_o, busy_o, done_o, result_o, RDaddr_o, RegWrite_o
    );

    modport slave (
        input  start_i, ALUOp_i, funct_i, data1_i, data2_i, RDaddr_i, RegWrite_i,
        output stall_o, busy_o, done_o, result_o, RDaddr_o, RegWrite_o
    );
endinterface

// File: rtl/ex_iter_mul_core.sv
// ---------------------------------------------------------------------------
// iter_mul_core
// Radix-2 shift-add datapath: accumulator, shifting multiplicand/multiplier
// and iteration counter.
//   clk_i     clock, rising edge
//   rst_i     asynchronous active-high reset, clears all registers
//   load_i    capture operands, clear accumulator and counter
//   step_i    perform one shift-add iteration
//   mcand_i   multiplicand to load
//   mplier_i  multiplier to load
//   acc_o     accumulated product (low WIDTH bits)
//   last_o    the iteration performed this cycle is the final one
// ---------------------------------------------------------------------------
module iter_mul_core #(
    parameter int WIDTH      = 32,
    parameter int EARLY_EXIT = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] mcand_i,
    input  logic [WIDTH-1:0] mplier_i,
    output logic [WIDTH-1:0] acc_o,
    output logic             last_o
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] acc_q,    acc_d;
    logic [WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CW-1:0]    count_q,  count_d;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        if (load_i) begin
            acc_d    = '0;
            mcand_d  = mcand_i;
            mplier_d = mplier_i;
            count_d  = '0;
        end else if (step_i) begin
            // carry out of the top bit is dropped: only the low WIDTH bits are kept
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
        end
    end

    // Early exit looks at the multiplier as it will be after this shift:
    // once only zero bits remain, the accumulator cannot change any more.
    always_comb begin
        last_o = (count_q == LAST_CNT);
        if (EARLY_EXIT != 0 && mplier_q[WIDTH-1:1] == '0) begin
            last_o = 1'b1;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/ex_iter_mul.sv
// ---------------------------------------------------------------------------
// ex_iter_mul
// EX-stage sequencer for RV32M MUL. Decodes the ID/EX instruction, stalls
// the front of the pipeline while an iterative shift-add multiply runs, and
// presents the low product bits with rd on a one-cycle done pulse. Other
// instructions pass through without affecting this block.
//   clk_i   clock, rising edge
//   rst_i   asynchronous active-high reset
//   bus     ex_iter_mul_if slave port (decode inputs, operands, stall/done/result)
// ---------------------------------------------------------------------------
module ex_iter_mul
    import ex_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int EARLY_EXIT = 0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    ex_iter_mul_if.slave bus
);
    state_t           state_q, state_d;
    logic             mul_req;
    logic             load, step, stall_c;
    logic [WIDTH-1:0] acc;
    logic             last;
    logic [4:0]       rd_q;
    logic             rw_q;
    logic [WIDTH-1:0] result_q;
    logic [4:0]       rd_out_q;

    assign mul_req = is_mul(bus.ALUOp_i, bus.funct_i);

    iter_mul_core #(
        .WIDTH      (WIDTH),
        .EARLY_EXIT (EARLY_EXIT)
    ) u_core (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (load),
        .step_i   (step),
        .mcand_i  (bus.data1_i),
        .mplier_i (bus.data2_i),
        .acc_o    (acc),
        .last_o   (last)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        stall_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start_i && mul_req) begin
                    stall_c = 1'b1;
                    load    = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // stall holds even while start_i is low so the pipeline cannot
                // slip past a half-finished multiply
                stall_c = 1'b1;
                if (bus.start_i) begin
                    step = 1'b1;
                    if (last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // ID/EX still shows the finished MUL here, so mul_req is ignored
                if (bus.start_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            rd_q     <= '0;
            rw_q     <= 1'b0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                rd_q <= bus.RDaddr_i;
                rw_q <= bus.RegWrite_i;
            end
            // keep a copy of the finished result so the outputs hold after the
            // core is reloaded by the next multiply
            if (state_q == DONE && bus.start_i) begin
                result_q <= acc;
                rd_out_q <= rd_q;
            end
        end
    end

    // stall is masked during reset so every output reads zero while rst_i is high
    assign bus.stall_o    = stall_c & ~rst_i;
    assign bus.busy_o     = (state_q == BUSY);
    assign bus.done_o     = (state_q == DONE);
    assign bus.result_o   = (state_q == DONE) ? acc  : result_q;
    assign bus.RDaddr_o   = (state_q == DONE) ? rd_q : rd_out_q;
    assign bus.RegWrite_o = (state_q == DONE) & rw_q;

endmodule

// File: tb/tb_ex_iter_mul.sv
module tb_ex_iter_mul;
    import ex_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ex_iter_mul_if #(.WIDTH(W)) bus0 ();
    ex_iter_mul_if #(.WIDTH(W)) bus1 ();

    ex_iter_mul #(.WIDTH(W), .EARLY_EXIT(0)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus0)
    );

    ex_iter_mul #(.WIDTH(W), .EARLY_EXIT(1)) dut_ee (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus1)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        rw;
        int          cyc;
        int          stall;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   scnt[2];
    int   checks = 0;
    int   errors = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: number of BUSY iterations. Without early exit every
    // multiply takes WIDTH iterations; with it, iteration stops after the
    // highest set multiplier bit (at least one iteration).
    function automatic int iters(input bit ee, input logic [31:0] b);
        int n;
        if (!ee) return W;
        n = 1;
        for (int i = 0; i < W; i++) if (b[i]) n = i + 1;
        return n;
    endfunction

    task automatic mon(input int w, input logic stall, input logic done,
                       input logic [31:0] res, input logic [4:0] rd, input logic rw);
        exp_t e;
        if (rst) begin
            scnt[w] = 0;
            return;
        end
        if (stall) scnt[w]++;
        if (done) begin
            if ((w == 0 && q0.size() == 0) || (w == 1 && q1.size() == 0)) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done dut%0d: result %0h at cycle %0d, none expected", w, res, cyc);
            end else begin
                if (w == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                cmp($sformatf("result dut%0d", w), res, e.res);
                cmp($sformatf("rd dut%0d", w), 32'(rd), 32'(e.rd));
                cmp($sformatf("regwrite dut%0d", w), 32'(rw), 32'(e.rw));
                cmp($sformatf("done_cycle dut%0d", w), 32'(cyc), 32'(e.cyc));
                cmp($sformatf("stall_cycles dut%0d", w), 32'(scnt[w]), 32'(e.stall));
            end
            scnt[w] = 0;
        end
    endtask

    always @(negedge clk) begin
        mon(0, bus0.stall_o, bus0.done_o, bus0.result_o, bus0.RDaddr_o, bus0.RegWrite_o);
        mon(1, bus1.stall_o, bus1.done_o, bus1.result_o, bus1.RDaddr_o, bus1.RegWrite_o);
    end

    task automatic set_instr(input bit w, input logic [1:0] op, input logic [9:0] fn,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rd, input logic rw, input logic st);
        if (!w) begin
            bus0.ALUOp_i = op; bus0.funct_i = fn; bus0.data1_i = a; bus0.data2_i = b;
            bus0.RDaddr_i = rd; bus0.RegWrite_i = rw; bus0.start_i = st;
        end else begin
            bus1.ALUOp_i = op; bus1.funct_i = fn; bus1.data1_i = a; bus1.data2_i = b;
            bus1.RDaddr_i = rd; bus1.RegWrite_i = rw; bus1.start_i = st;
        end
    endtask

    task automatic nop(input bit w);
        set_instr(w, 2'b00, 10'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
    endtask

    task automatic set_start(input bit w, input logic st);
        if (!w) bus0.start_i = st;
        else    bus1.start_i = st;
    endtask

    // Called just after a clock edge; presents a MUL in ID/EX and holds it
    // until the done cycle, then moves ID/EX on to a bubble.
    task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic rw,
                         input int pause_at, input int pause_len);
        exp_t e;
        int   n;
        bit   seen;
        n       = iters(w, b);
        e.res   = a * b;
        e.rd    = rd;
        e.rw    = rw;
        e.cyc   = cyc + 1 + n + pause_len;
        e.stall = n + 1 + pause_len;
        if (!w) q0.push_back(e);
        else    q1.push_back(e);
        set_instr(w, ALUOP_RTYPE, FUNCT_MUL, a, b, rd, rw, 1'b1);
        seen = 1'b0;
        for (int i = 1; i <= 200 && !seen; i++) begin
            @(posedge clk); #1;
            if (pause_len > 0 && i == pause_at) set_start(w, 1'b0);
            if (pause_len > 0 && i == pause_at + pause_len) set_start(w, 1'b1);
            seen = w ? bus1.done_o : bus0.done_o;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL timeout dut%0d: no done_o for %0h x %0h, expected one", w, a, b);
        end
        @(posedge clk); #1;
        nop(w);
    endtask

    task automatic check_quiet(input string nm);
        @(negedge clk);
        cmp({nm, " stall"}, 32'(bus0.stall_o), 32'd0);
        cmp({nm, " done"},  32'(bus0.done_o),  32'd0);
        cmp({nm, " busy"},  32'(bus0.busy_o),  32'd0);
    endtask

    task automatic check_zero(input string nm);
        cmp({nm, " stall"},    32'(bus0.stall_o),    32'd0);
        cmp({nm, " busy"},     32'(bus0.busy_o),     32'd0);
        cmp({nm, " done"},     32'(bus0.done_o),     32'd0);
        cmp({nm, " result"},   bus0.result_o,        32'd0);
        cmp({nm, " rdaddr"},   32'(bus0.RDaddr_o),   32'd0);
        cmp({nm, " regwrite"}, 32'(bus0.RegWrite_o), 32'd0);
    endtask

    initial begin
        logic [31:0] a, b;
        nop(0);
        nop(1);
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        issue(0, 32'd3, 32'd5, 5'd7, 1'b1, 0, 0);
        issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 1'b1, 0, 0);
        issue(0, 32'h8000_0000, 32'd2, 5'd31, 1'b0, 0, 0);
        issue(0, 32'd7, 32'd6, 5'd1, 1'b1, 0, 0);
        issue(0, 32'd9, 32'd9, 5'd2, 1'b1, 0, 0);

        // ADD then LW: neither may start the multiplier
        set_instr(0, ALUOP_RTYPE, 10'd0, 32'd4, 32'd5, 5'd3, 1'b1, 1'b1);
        check_quiet("add");
        @(posedge clk); #1;
        set_instr(0, 2'b00, FUNCT_MUL, 32'd4, 32'd5, 5'd3, 1'b1, 1'b1);
        check_quiet("lw");
        @(posedge clk); #1;
        check_quiet("lw_after");
        @(posedge clk); #1;
        nop(0);

        issue(0, 32'd11, 32'd13, 5'd9, 1'b1, 5, 4);

        // reset in the middle of a multiply
        set_instr(0, ALUOP_RTYPE, FUNCT_MUL, 32'd100, 32'd200, 5'd3, 1'b1, 1'b1);
        repeat (10) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        check_zero("midreset");
        nop(0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        cmp("post_reset busy", 32'(bus0.busy_o), 32'd0);
        issue(0, 32'd5, 32'd5, 5'd4, 1'b1, 0, 0);

        issue(1, 32'd12, 32'd0, 5'd5, 1'b1, 0, 0);
        issue(1, 32'd12, 32'd1, 5'd6, 1'b1, 0, 0);

        for (int k = 0; k < 10; k++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            issue(0, a, b, 5'($urandom), 1'($urandom), 0, 0);
        end
        for (int k = 0; k < 12; k++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            issue(1, a, b, 5'($urandom), 1'($urandom), 0, 0);
        end

        repeat (5) @(posedge clk);
        #1;
        cmp("pending dut0", 32'(q0.size()), 32'd0);
        cmp("pending dut1", 32'(q1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
